if_fetch_queue: RTL and testbench

- Parametrised successor of the single-PC fetch stage: issues FETCH_W-instruction aligned fetch groups to the icache over a req/addr_ok/data_ok split handshake.
- Tracks up to QDEPTH outstanding requests in an in-order PC queue.
- Squashes in-flight responses on redirect.
- Sequences branch delay slots through a small FSM.
- Sits between the branch predictor / icache and decode (ID).

---
 rtl/if_fetch_queue.sv | 175 +++++++++++++++++
 tb/tb_if_fetch_queue.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Fetch stage with an in-order queue of outstanding icache requests, redirect squashing
// and a delay-slot FSM. Define IF_PERF_CNT_EN to build the request/kill performance counters.
module if_fetch_queue #(
  parameter int                ADDR_W       = 32,
  parameter int                FETCH_W      = 4,
  parameter int                QDEPTH       = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              bp_if_en,
  input  logic [ADDR_W-1:0] bp_if_target,
  input  logic              bp_if_delot_en,
  input  logic [ADDR_W-1:0] bp_if_delot_pc,
  output logic [ADDR_W-1:0] if_bp_pc,
  input  logic              ex_bp_error,
  input  logic [ADDR_W-1:0] ex_new_target,
  input  logic              exc_flush_all,
  input  logic [ADDR_W-1:0] cp0_if_excaddr,
  output logic              if_icache_req,
  output logic [ADDR_W-1:0] if_icache_pc,
  input  logic              icache_addr_ok,
  input  logic              icache_data_ok,
  output logic              if_resp_ready,
  input  logic              id_allin,
  output logic              if_resp_valid,
  output logic [ADDR_W-1:0] if_resp_pc,
  output logic [FETCH_W-1:0] if_resp_mask,
  output logic              if_resp_delot,
  output logic [31:0]       if_perf_req_cnt,
  output logic [31:0]       if_perf_kill_cnt
);

  localparam int OFF_W = (FETCH_W > 1) ? $clog2(FETCH_W) : 1;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam logic [ADDR_W-1:0]  GRP_BYTES = ADDR_W'(FETCH_W * 4);
  localparam logic [PTR_W:0]     FULL_CNT  = (PTR_W + 1)'(QDEPTH);
  localparam logic [FETCH_W-1:0] MASK_ALL  = '1;
  localparam logic [FETCH_W-1:0] MASK_ONE  = FETCH_W'(1);

  typedef enum logic {SEQ, DELOT} state_t;

  state_t            state, state_nxt;
  logic              run;
  logic [ADDR_W-1:0] pc, pc_nxt, tgt, tgt_nxt, seq_pc;
  logic [OFF_W-1:0]  off;
  logic [FETCH_W-1:0] push_mask;

  logic [ADDR_W-1:0]  q_pc    [QDEPTH];
  logic [FETCH_W-1:0] q_mask  [QDEPTH];
  logic [QDEPTH-1:0]  q_delot;
  logic [QDEPTH-1:0]  q_stale;
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count;

  logic full, hs, pop, redirect;

  assign full          = (count == FULL_CNT);
  assign if_icache_req = run & ~full & id_allin;
  assign hs            = if_icache_req & icache_addr_ok;
  assign pop           = icache_data_ok & (count != '0);
  assign redirect      = exc_flush_all | ex_bp_error;
  assign if_bp_pc      = pc;
  assign if_icache_pc  = pc;
  assign if_resp_ready = id_allin;

  assign off       = (FETCH_W > 1) ? pc[OFF_W+1:2] : '0;
  assign push_mask = (state == DELOT) ? (MASK_ONE << off) : (MASK_ALL << off);
  assign seq_pc    = (pc & ~(GRP_BYTES - 1'b1)) + GRP_BYTES;

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    tgt_nxt   = tgt;
    if (hs) begin
      if (state == SEQ) begin
        if (bp_if_delot_en) begin
          pc_nxt    = bp_if_delot_pc;
          tgt_nxt   = bp_if_target;
          state_nxt = DELOT;
        end else if (bp_if_en) begin
          pc_nxt = bp_if_target;
        end else begin
          pc_nxt = seq_pc;
        end
      end else begin
        pc_nxt    = tgt;
        state_nxt = SEQ;
      end
    end
    // Redirects override whatever the handshake decided this cycle
    if (exc_flush_all) begin
      pc_nxt    = cp0_if_excaddr;
      state_nxt = SEQ;
    end else if (ex_bp_error) begin
      pc_nxt    = ex_new_target;
      state_nxt = SEQ;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      state  <= SEQ;
      run    <= 1'b0;
      pc     <= RESET_VECTOR;
      tgt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      state <= state_nxt;
      run   <= 1'b1;
      pc    <= pc_nxt;
      tgt   <= tgt_nxt;
      if (hs)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({hs, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Queue storage; an entry pushed during a redirect is born stale
  always_ff @(posedge clk) begin
    if (redirect) q_stale <= '1;
    if (hs) begin
      q_pc[wr_ptr]    <= pc;
      q_mask[wr_ptr]  <= push_mask;
      q_delot[wr_ptr] <= (state == DELOT);
      q_stale[wr_ptr] <= redirect;
    end
  end

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      if_resp_valid <= 1'b0;
      if_resp_pc    <= '0;
      if_resp_mask  <= '0;
      if_resp_delot <= 1'b0;
    end else begin
      if_resp_valid <= pop & ~q_stale[rd_ptr] & ~redirect;
      if (pop) begin
        if_resp_pc    <= q_pc[rd_ptr];
        if_resp_mask  <= q_mask[rd_ptr];
        if_resp_delot <= q_delot[rd_ptr];
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  logic        kill;
  logic [31:0] req_cnt, kill_cnt;

  assign kill = pop & (q_stale[rd_ptr] | redirect);

  always_ff @(posedge clk or posedge rst_) begin
    if (rst_) begin
      req_cnt  <= '0;
      kill_cnt <= '0;
    end else begin
      if (hs)   req_cnt  <= req_cnt + 1'b1;
      if (kill) kill_cnt <= kill_cnt + 1'b1;
    end
  end

  assign if_perf_req_cnt  = req_cnt;
  assign if_perf_kill_cnt = kill_cnt;
`else
  assign if_perf_req_cnt  = '0;
  assign if_perf_kill_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed, table-driven bench for if_fetch_queue (FETCH_W=4, QDEPTH=4) plus a second
// instance with RESET_VECTOR=32'hFFFFFFF0 for the address-wrap case.
module tb_if_fetch_queue;

  typedef struct {
    logic        aok, dok, bpen;
    logic [31:0] bptgt;
    logic        dlen;
    logic [31:0] dlpc;
    logic        err;
    logic [31:0] ntgt;
    logic        fl;
    logic [31:0] exc;
    logic        ereq;
    logic [31:0] epc;
    logic        erv;
    logic [31:0] erpc;
    logic [3:0]  emask;
    logic        edl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_;
  logic        bp_if_en, bp_if_delot_en, ex_bp_error, exc_flush_all;
  logic [31:0] bp_if_target, bp_if_delot_pc, ex_new_target, cp0_if_excaddr;
  logic        icache_addr_ok, icache_data_ok, id_allin;

  logic        req, resp_ready, resp_valid, resp_delot;
  logic [31:0] bp_pc, icache_pc, resp_pc, perf_req, perf_kill;
  logic [3:0]  resp_mask;

  logic        req2, resp_ready2, resp_valid2, resp_delot2;
  logic [31:0] bp_pc2, icache_pc2, resp_pc2, perf_req2, perf_kill2;
  logic [3:0]  resp_mask2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  if_fetch_queue #(.ADDR_W(32), .FETCH_W(4), .QDEPTH(4), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst_(rst_),
    .bp_if_en(bp_if_en), .bp_if_target(bp_if_target),
    .bp_if_delot_en(bp_if_delot_en), .bp_if_delot_pc(bp_if_delot_pc),
    .if_bp_pc(bp_pc),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target),
    .exc_flush_all(exc_flush_all), .cp0_if_excaddr(cp0_if_excaddr),
    .if_icache_req(req), .if_icache_pc(icache_pc),
    .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
    .if_resp_ready(resp_ready), .id_allin(id_allin),
    .if_resp_valid(resp_valid), .if_resp_pc(resp_pc),
    .if_resp_mask(resp_mask), .if_resp_delot(resp_delot),
    .if_perf_req_cnt(perf_req), .if_perf_kill_cnt(perf_kill)
  );

  if_fetch_queue #(.ADDR_W(32), .FETCH_W(4), .QDEPTH(4), .RESET_VECTOR(32'hFFFF_FFF0)) dut2 (
    .clk(clk), .rst_(rst_),
    .bp_if_en(bp_if_en), .bp_if_target(bp_if_target),
    .bp_if_delot_en(bp_if_delot_en), .bp_if_delot_pc(bp_if_delot_pc),
    .if_bp_pc(bp_pc2),
    .ex_bp_error(ex_bp_error), .ex_new_target(ex_new_target),
    .exc_flush_all(exc_flush_all), .cp0_if_excaddr(cp0_if_excaddr),
    .if_icache_req(req2), .if_icache_pc(icache_pc2),
    .icache_addr_ok(icache_addr_ok), .icache_data_ok(icache_data_ok),
    .if_resp_ready(resp_ready2), .id_allin(id_allin),
    .if_resp_valid(resp_valid2), .if_resp_pc(resp_pc2),
    .if_resp_mask(resp_mask2), .if_resp_delot(resp_delot2),
    .if_perf_req_cnt(perf_req2), .if_perf_kill_cnt(perf_kill2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bp_if_en = 0; bp_if_target = '0; bp_if_delot_en = 0; bp_if_delot_pc = '0;
    ex_bp_error = 0; ex_new_target = '0; exc_flush_all = 0; cp0_if_excaddr = '0;
    icache_addr_ok = 0; icache_data_ok = 0; id_allin = 1;
  endtask

  // Entered at a falling edge: drive, check one step later, move to the next falling edge.
  task automatic apply(input int k, input vec_t v);
    icache_addr_ok = v.aok;   icache_data_ok = v.dok;
    bp_if_en       = v.bpen;  bp_if_target   = v.bptgt;
    bp_if_delot_en = v.dlen;  bp_if_delot_pc = v.dlpc;
    ex_bp_error    = v.err;   ex_new_target  = v.ntgt;
    exc_flush_all  = v.fl;    cp0_if_excaddr = v.exc;
    id_allin       = 1'b1;
    #1;
    chk($sformatf("v%0d req", k),        {31'd0, req},        {31'd0, v.ereq});
    chk($sformatf("v%0d pc", k),         icache_pc,           v.epc);
    chk($sformatf("v%0d bp_pc", k),      bp_pc,               v.epc);
    chk($sformatf("v%0d resp_valid", k), {31'd0, resp_valid}, {31'd0, v.erv});
    chk($sformatf("v%0d resp_pc", k),    resp_pc,             v.erpc);
    chk($sformatf("v%0d resp_mask", k),  {28'd0, resp_mask},  {28'd0, v.emask});
    chk($sformatf("v%0d resp_delot", k), {31'd0, resp_delot}, {31'd0, v.edl});
    @(negedge clk);
  endtask

  vec_t vt[40];

  initial begin
    rst_ = 1'b1;
    set_idle();

    //        aok dok bpen bptgt     dlen dlpc     err ntgt      fl exc      ereq epc       erv erpc      emask  edl
    vt[0]  = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h000, 0, 32'h000, 4'h0, 0};
    vt[1]  = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h000, 0, 32'h000, 4'h0, 0};
    vt[2]  = '{1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 32'h000, 4'h0, 0};
    vt[3]  = '{1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h020, 1, 32'h000, 4'hF, 0};
    vt[4]  = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h030, 1, 32'h010, 4'hF, 0};
    vt[5]  = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h030, 1, 32'h020, 4'hF, 0};
    vt[6]  = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h030, 0, 32'h020, 4'hF, 0};
    vt[7]  = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h030, 0, 32'h020, 4'hF, 0};
    vt[8]  = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h040, 0, 32'h020, 4'hF, 0};
    vt[9]  = '{0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h108, 0, 32'h0,   1, 32'h050, 0, 32'h020, 4'hF, 0};
    vt[10] = '{1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h108, 0, 32'h020, 4'hF, 0};
    vt[11] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h110, 0, 32'h030, 4'hF, 0};
    vt[12] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h110, 0, 32'h040, 4'hF, 0};
    vt[13] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h110, 1, 32'h108, 4'hC, 0};
    vt[14] = '{0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h010, 0, 32'h0,   1, 32'h110, 0, 32'h108, 4'hC, 0};
    vt[15] = '{1, 0, 1, 32'h400, 1, 32'h20, 0, 32'h0,   0, 32'h0,   1, 32'h010, 0, 32'h108, 4'hC, 0};
    vt[16] = '{1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h020, 0, 32'h108, 4'hC, 0};
    vt[17] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h400, 1, 32'h010, 4'hF, 0};
    vt[18] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h400, 1, 32'h020, 4'h1, 1};
    vt[19] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h020, 4'h1, 1};
    vt[20] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h400, 0, 32'h020, 4'h1, 1};
    vt[21] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h410, 0, 32'h020, 4'h1, 1};
    vt[22] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h420, 0, 32'h020, 4'h1, 1};
    vt[23] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h430, 0, 32'h020, 4'h1, 1};
    vt[24] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h440, 0, 32'h020, 4'h1, 1};
    vt[25] = '{1, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   0, 32'h440, 0, 32'h020, 4'h1, 1};
    vt[26] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h440, 1, 32'h400, 4'hF, 0};
    vt[27] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h440, 0, 32'h400, 4'hF, 0};
    vt[28] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h440, 1, 32'h410, 4'hF, 0};
    vt[29] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h440, 1, 32'h420, 4'hF, 0};
    vt[30] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h440, 1, 32'h430, 4'hF, 0};
    vt[31] = '{0, 0, 0, 32'h0,   0, 32'h0,  1, 32'h500, 1, 32'h380, 1, 32'h440, 0, 32'h430, 4'hF, 0};
    vt[32] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h430, 4'hF, 0};
    vt[33] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h380, 0, 32'h430, 4'hF, 0};
    vt[34] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h390, 0, 32'h430, 4'hF, 0};
    vt[35] = '{1, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h390, 1, 32'h380, 4'hF, 0};
    vt[36] = '{0, 1, 0, 32'h0,   0, 32'h0,  1, 32'h200, 0, 32'h0,   1, 32'h3A0, 0, 32'h380, 4'hF, 0};
    vt[37] = '{1, 0, 0, 32'h0,   0, 32'h0,  1, 32'h600, 0, 32'h0,   1, 32'h200, 0, 32'h390, 4'hF, 0};
    vt[38] = '{0, 1, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h600, 0, 32'h390, 4'hF, 0};
    vt[39] = '{0, 0, 0, 32'h0,   0, 32'h0,  0, 32'h0,   0, 32'h0,   1, 32'h600, 0, 32'h200, 4'hF, 0};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst req",        {31'd0, req},        32'd0);
    chk("rst resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst resp_pc",    resp_pc,             32'd0);
    chk("rst resp_mask",  {28'd0, resp_mask},  32'd0);
    chk("rst resp_delot", {31'd0, resp_delot}, 32'd0);
    chk("rst pc",         bp_pc,               32'd0);
    chk("rst pc2",        bp_pc2,              32'hFFFF_FFF0);
    chk("rst perf_req",   perf_req,            32'd0);
    chk("rst perf_kill",  perf_kill,           32'd0);

    @(negedge clk);
    rst_ = 1'b0;
    for (int k = 0; k < 40; k++) apply(k, vt[k]);

    // Decode back-pressure gates requests and response readiness
    set_idle();
    icache_addr_ok = 1;
    id_allin = 0;
    #1;
    chk("stall req",        {31'd0, req},        32'd0);
    chk("stall resp_ready", {31'd0, resp_ready}, 32'd0);
    @(negedge clk);
    id_allin = 1;
    #1;
    chk("stall pc held",    icache_pc,           32'h600);
    chk("unstall req",      {31'd0, req},        32'd1);
    chk("unstall ready",    {31'd0, resp_ready}, 32'd1);
    icache_addr_ok = 0;
    @(negedge clk);

`ifdef IF_PERF_CNT_EN
    chk("perf_req",  perf_req,  32'd15);
    chk("perf_kill", perf_kill, 32'd4);
`else
    chk("perf_req",  perf_req,  32'd0);
    chk("perf_kill", perf_kill, 32'd0);
`endif

    // Asynchronous reset mid-run, then address wrap from the high reset vector
    #2 rst_ = 1'b1;
    #1;
    chk("arst pc",         bp_pc,               32'd0);
    chk("arst req",        {31'd0, req},        32'd0);
    chk("arst resp_pc",    resp_pc,             32'd0);
    chk("arst resp_mask",  {28'd0, resp_mask},  32'd0);
    chk("arst pc2",        bp_pc2,              32'hFFFF_FFF0);
    @(negedge clk);
    @(negedge clk);
    rst_ = 1'b0;
    icache_addr_ok = 1;
    #1;
    chk("wrap run0 req", {31'd0, req2}, 32'd0);
    @(negedge clk);
    #1;
    chk("wrap req1",     {31'd0, req2}, 32'd1);
    chk("wrap pc1",      icache_pc2,    32'hFFFF_FFF0);
    @(negedge clk);
    icache_data_ok = 1;
    #1;
    chk("wrap pc2",      icache_pc2,    32'h0000_0000);
    @(negedge clk);
    icache_addr_ok = 0;
    icache_data_ok = 0;
    #1;
    chk("wrap resp_valid", {31'd0, resp_valid2}, 32'd1);
    chk("wrap resp_pc",    resp_pc2,             32'hFFFF_FFF0);
    chk("wrap resp_mask",  {28'd0, resp_mask2},  32'hF);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
